// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and control-word field layout for the pipeline latches
//
// Control word layout (default 8 bits, MSB first): WB[1:0] | M[1:0] | EX[3:0].
// Downstream stages slice ctrl_o with the *_LSB / *_W pairs below rather than
// through dedicated per-field ports.
package pipe_pkg;

    localparam int CTRL_W_DEF = 8;
    localparam int RIDX_W_DEF = 5;

    // Field widths inside the control word
    localparam int EX_W = 4;
    localparam int M_W  = 2;
    localparam int WB_W = 2;

    // Field offsets inside the control word
    localparam int EX_LSB = 0;
    localparam int M_LSB  = EX_LSB + EX_W;
    localparam int WB_LSB = M_LSB + M_W;

    // A bubble carries an all-zero control word: no register write, no memory
    // access, no EX side effects.
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-high reset, clears the count
//   inc_i  in   count one event this cycle
//   clr_i  in   synchronous clear; wins over inc_i
//   cnt_o  out  current count, sticks at 2^CNT_W-1
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - parametrised ID/EX pipeline latch with stall, flush and debug counters
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-high reset
//   valid_i       in   ID stage holds a real instruction
//   ctrl_i        in   decoded control word
//   data_i        in   operand payload (rs data, rt data, immediate)
//   ridx_i        in   packed register indices, field k at [k*RIDX_W +: RIDX_W]
//   stall_i       in   hold current contents
//   flush_i       in   replace contents with a bubble (beats stall_i)
//   cnt_clr_i     in   synchronous clear of both event counters
//   valid_o       out  EX-stage instruction valid
//   ctrl_o        out  registered control word
//   data_o        out  registered payload
//   ridx_o        out  registered register indices
//   stall_cnt_o   out  saturating count of stalled cycles
//   bubble_cnt_o  out  saturating count of bubbles loaded
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter int                DATA_W      = 96,
    parameter int                RIDX_W      = RIDX_W_DEF,
    parameter int                RIDX_N      = 3,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
    parameter int                CNT_W       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic [RIDX_N*RIDX_W-1:0] ridx_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     cnt_clr_i,
    output logic                     valid_o,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [RIDX_N*RIDX_W-1:0] ridx_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);

    // A stall only counts when no flush overrides it.
    logic stall_event;
    // Bubble loaded either by flush or by an advance with no real instruction.
    logic bubble_event;

    assign stall_event  = stall_i & ~flush_i;
    assign bubble_event = flush_i | (~stall_i & ~valid_i);

    // Flush > stall > advance. Bubbles zero the register indices so the
    // forwarding comparators can never match on them ($0 is never forwarded).
    // data_o is left alone on flush: it is don't-care once valid_o is low and
    // holding it saves a mux leg on the wide payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= BUBBLE_CTRL;
            data_o  <= '0;
            ridx_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= BUBBLE_CTRL;
            ridx_o  <= '0;
        end else if (!stall_i) begin
            data_o <= data_i;
            if (valid_i) begin
                valid_o <= 1'b1;
                ctrl_o  <= ctrl_i;
                ridx_o  <= ridx_i;
            end else begin
                valid_o <= 1'b0;
                ctrl_o  <= BUBBLE_CTRL;
                ridx_o  <= '0;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(stall_event),
        .clr_i(cnt_clr_i),
        .cnt_o(stall_cnt_o)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(bubble_event),
        .clr_i(cnt_clr_i),
        .cnt_o(bubble_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
    import pipe_pkg::*;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 96;
    localparam int RIDX_W = 5;
    localparam int RIDX_N = 3;
    localparam int CNT_W  = 4;

    logic                     clk;
    logic                     rst;
    logic                     valid_i;
    logic [CTRL_W-1:0]        ctrl_i;
    logic [DATA_W-1:0]        data_i;
    logic [RIDX_N*RIDX_W-1:0] ridx_i;
    logic                     stall_i;
    logic                     flush_i;
    logic                     cnt_clr_i;
    logic                     valid_o;
    logic [CTRL_W-1:0]        ctrl_o;
    logic [DATA_W-1:0]        data_o;
    logic [RIDX_N*RIDX_W-1:0] ridx_o;
    logic [CNT_W-1:0]         stall_cnt_o;
    logic [CNT_W-1:0]         bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .RIDX_W     (RIDX_W),
        .RIDX_N     (RIDX_N),
        .BUBBLE_CTRL(8'h00),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ctrl_i      (ctrl_i),
        .data_i      (data_i),
        .ridx_i      (ridx_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .cnt_clr_i   (cnt_clr_i),
        .valid_o     (valid_o),
        .ctrl_o      (ctrl_o),
        .data_o      (data_o),
        .ridx_o      (ridx_o),
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0]        d_adv;
    logic [DATA_W-1:0]        d_rel;
    logic [DATA_W-1:0]        d_keep;
    logic [DATA_W-1:0]        d_idle;
    logic [RIDX_N*RIDX_W-1:0] r_adv;
    logic [RIDX_N*RIDX_W-1:0] r_rel;
    logic [CTRL_W-1:0]        c_tmp;

    initial begin
        d_adv  = {32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFF0};
        d_rel  = {32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        d_keep = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
        d_idle = {32'h5555_AAAA, 32'hAAAA_5555, 32'h0000_FFFF};
        r_adv  = {5'd3, 5'd8, 5'd9};
        r_rel  = {5'd1, 5'd2, 5'd3};

        rst       = 1'b1;
        valid_i   = 1'b1;
        ctrl_i    = 8'hA5;
        data_i    = 96'h0BAD_0BAD_0BAD;
        ridx_i    = {5'd4, 5'd5, 5'd6};
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        cnt_clr_i = 1'b0;

        tick();
        tick();
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_ctrl", ctrl_o, 8'h00);
        rst = 1'b0;

        // First capture after reset release
        tick();
        chk("first_valid", valid_o, 1'b1);
        chk("first_ctrl", ctrl_o, 8'hA5);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", valid_o, 1'b0);
        chk("async_ctrl", ctrl_o, 8'h00);
        chk("async_data", data_o, 96'h0);
        chk("async_ridx", ridx_o, 15'h0);
        chk("async_stall_cnt", stall_cnt_o, 4'd0);
        chk("async_bubble_cnt", bubble_cnt_o, 4'd0);
        tick();
        chk("reset_held_ctrl", ctrl_o, 8'h00);
        chk("reset_held_valid", valid_o, 1'b0);
        rst = 1'b0;

        // Advance a real instruction
        valid_i = 1'b1;
        ctrl_i  = 8'h3C;
        data_i  = d_adv;
        ridx_i  = r_adv;
        tick();
        chk("adv_valid", valid_o, 1'b1);
        chk("adv_ctrl", ctrl_o, 8'h3C);
        chk("adv_data", data_o, d_adv);
        chk("adv_ridx", ridx_o, r_adv);
        chk("adv_wb_field", ctrl_o[WB_LSB +: WB_W], 2'b00);
        chk("adv_m_field", ctrl_o[M_LSB +: M_W], 2'b11);
        chk("adv_ex_field", ctrl_o[EX_LSB +: EX_W], 4'hC);

        // Stall 4 cycles with changing inputs: outputs frozen
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_tmp   = 8'h10 + 8'(i);
            ctrl_i  = c_tmp;
            data_i  = {32'(i), 32'hDEAD_BEEF, 32'(i + 7)};
            ridx_i  = {5'(i + 10), 5'(i + 11), 5'(i + 12)};
            valid_i = i[0];
            tick();
            chk("stall_ctrl", ctrl_o, 8'h3C);
            chk("stall_data", data_o, d_adv);
            chk("stall_ridx", ridx_o, r_adv);
            chk("stall_valid", valid_o, 1'b1);
        end
        chk("stall_cnt_4", stall_cnt_o, 4'd4);
        chk("stall_bubble_cnt", bubble_cnt_o, 4'd0);

        // Release: new inputs captured next edge
        stall_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = 8'h5A;
        data_i  = d_rel;
        ridx_i  = r_rel;
        tick();
        chk("rel_ctrl", ctrl_o, 8'h5A);
        chk("rel_data", data_o, d_rel);
        chk("rel_ridx", ridx_o, r_rel);
        chk("rel_stall_cnt", stall_cnt_o, 4'd4);

        // Flush beats stall; data holds
        stall_i = 1'b1;
        flush_i = 1'b1;
        ctrl_i  = 8'h77;
        data_i  = d_idle;
        tick();
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_ctrl", ctrl_o, 8'h00);
        chk("flush_ridx", ridx_o, 15'h0);
        chk("flush_data_hold", data_o, d_rel);
        chk("flush_bubble_cnt", bubble_cnt_o, 4'd1);
        chk("flush_stall_cnt", stall_cnt_o, 4'd4);

        // Advance, stall one cycle, then flush on the next cycle
        stall_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = 8'h66;
        data_i  = d_keep;
        ridx_i  = r_adv;
        tick();
        chk("pre_stall_ctrl", ctrl_o, 8'h66);
        stall_i = 1'b1;
        ctrl_i  = 8'h99;
        tick();
        chk("one_stall_ctrl", ctrl_o, 8'h66);
        chk("one_stall_cnt", stall_cnt_o, 4'd5);
        flush_i = 1'b1;
        tick();
        chk("stall_flush_valid", valid_o, 1'b0);
        chk("stall_flush_ctrl", ctrl_o, 8'h00);
        chk("stall_flush_ridx", ridx_o, 15'h0);
        chk("stall_flush_data", data_o, d_keep);
        chk("stall_flush_bubble_cnt", bubble_cnt_o, 4'd2);
        chk("stall_flush_stall_cnt", stall_cnt_o, 4'd5);

        // Idle advance: bubble, but payload is loaded
        stall_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ctrl_i  = 8'hFF;
        data_i  = d_idle;
        ridx_i  = {5'd7, 5'd7, 5'd7};
        tick();
        chk("idle_valid", valid_o, 1'b0);
        chk("idle_ctrl", ctrl_o, 8'h00);
        chk("idle_ridx", ridx_o, 15'h0);
        chk("idle_data", data_o, d_idle);
        chk("idle_bubble_cnt", bubble_cnt_o, 4'd3);

        // Clear counters on a plain valid advance
        valid_i   = 1'b1;
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_stall_cnt", stall_cnt_o, 4'd0);
        chk("clr_bubble_cnt", bubble_cnt_o, 4'd0);
        cnt_clr_i = 1'b0;

        // Stall 20 cycles: stall counter saturates at 15
        stall_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("sat_stall_cnt", stall_cnt_o, 4'd15);
        chk("sat_bubble_cnt", bubble_cnt_o, 4'd0);

        // Clear together with stall wins over the increment
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_with_stall", stall_cnt_o, 4'd0);
        cnt_clr_i = 1'b0;

        // Flush 17 cycles: bubble counter saturates, then clear with flush
        stall_i = 1'b0;
        flush_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        chk("sat_bubble_cnt_15", bubble_cnt_o, 4'd15);
        chk("flush_no_stall_cnt", stall_cnt_o, 4'd0);
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_with_flush", bubble_cnt_o, 4'd0);
        cnt_clr_i = 1'b0;
        flush_i   = 1'b0;

        // Reset asserted in the middle of a stall
        valid_i = 1'b1;
        ctrl_i  = 8'hC3;
        tick();
        stall_i = 1'b1;
        tick();
        chk("mid_stall_pre_ctrl", ctrl_o, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_stall_rst_ctrl", ctrl_o, 8'h00);
        chk("mid_stall_rst_cnt", stall_cnt_o, 4'd0);
        tick();
        rst     = 1'b0;
        stall_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised ID→EX pipeline latch for the five-stage core; successor to the fixed-width ID/EX register. Carries a control word, a data payload and N register-index fields across the boundary. Supports stall (hold), flush (bubble insertion) and a valid bit. Bubbles are made forwarding-safe, and saturating stall/bubble counters feed the hazard-debug path.

## Interface
- CTRL_W, 8: control word width (WB 2 + M 2 + EX 4 by default).
- DATA_W, 96: payload width (rs data, rt data, sign-extended imm).
- RIDX_W, 5: register-index width.
- RIDX_N, 3: number of register-index fields (rs, rt, rd).
- BUBBLE_CTRL, 0: control word loaded on a bubble; a CTRL_W-bit constant.
- CNT_W, 16: event counter width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  ID stage holds a real instruction.
- ctrl_i  in  CTRL_W  decoded control word.
- data_i  in  DATA_W  operand payload.
- ridx_i  in  RIDX_N*RIDX_W  packed register indices; field k occupies bits [k*RIDX_W +: RIDX_W].
- stall_i  in  1  hold current contents (hazard unit; replaces the old pcEnable_i, opposite polarity).
- flush_i  in  1  replace contents with a bubble.
- cnt_clr_i  in  1  synchronous clear of both counters.
- valid_o  out  1  EX-stage instruction valid.
- ctrl_o  out  CTRL_W  registered control word.
- data_o  out  DATA_W  registered payload.
- ridx_o  out  RIDX_N*RIDX_W  registered indices.
- stall_cnt_o  out  CNT_W  cycles spent stalled.
- bubble_cnt_o  out  CNT_W  bubbles inserted.

## Operation
- Per edge, mutually exclusive actions; priority flush > stall > advance.
- Flush (flush_i=1, regardless of stall_i):
  - valid_o←0, ctrl_o←BUBBLE_CTRL, ridx_o←0.
  - data_o holds.
- Stall (stall_i=1, flush_i=0): every pipeline output holds its value.
- Advance (both low):
  - With valid_i=1: valid_o←1, and ctrl_o, data_o, ridx_o load their inputs.
  - With valid_i=0: load as a bubble (same as flush, except data_o←data_i).
- Bubble ridx is 0 so forwarding comparators never match ($0 is never forwarded).
- stall_cnt_o increments each cycle with stall_i=1 and flush_i=0.
- bubble_cnt_o increments each cycle a bubble is loaded, i.e. on flush, or on advance with valid_i=0.
- Both counters saturate at 2^CNT_W−1; they do not wrap.
- cnt_clr_i=1 forces both counters to 0 that edge and overrides the increment.
- All updates are non-blocking; no combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge t appear on outputs after t.
- Reset asserted, at any time including mid-stall:
  - Immediately: valid_o=0, ctrl_o=BUBBLE_CTRL, data_o=0, ridx_o=0, both counters 0.
  - Held while rst_i=1.
- First capture occurs on the first rising edge after rst_i falls.
- Stall may last any number of cycles; outputs stay bit-identical throughout.
- Stall then flush on the next cycle: the bubble appears after that edge.
- Counter at max with an increment condition: stays at max. Clear in the same cycle: goes to 0.

## Structure
- Shared package pipe_pkg:
  - CTRL_W_DEF, RIDX_W_DEF.
  - BUBBLE_CTRL_DEF.
  - Control-field offset constants (WB_LSB, M_LSB, EX_LSB) so downstream stages slice ctrl_o by name instead of through separate EX1/EX2/EX3 ports.
- One sub-module, sat_counter, instantiated twice:
  - Parameter CNT_W.
  - Ports clk_i, rst_i, inc_i, clr_i, cnt_o.
- Core register is a single always block with async reset.

## Test plan
- Reset: drive rst_i=1 mid-cycle with ctrl_i=8'hA5, valid_i=1 → outputs clear immediately to valid_o=0, ctrl_o=8'h00, ridx_o=0, counters 0.
- Advance: valid_i=1, ctrl_i=8'h3C, data_i={32'h1,32'h2,32'hFFFF_FFF0}, ridx_i={5'd3,5'd8,5'd9} → next cycle the outputs equal those values and valid_o=1.
- Stall then release:
  - stall_i=1 for 4 cycles while inputs change each cycle → outputs frozen, stall_cnt_o=4.
  - Release → new inputs captured next edge.
- Flush beats stall: stall_i=1 and flush_i=1 together → valid_o=0, ctrl_o=BUBBLE_CTRL, ridx_o=0, data_o unchanged, bubble_cnt_o+1, stall_cnt_o unchanged.
- Saturation and clear:
  - CNT_W=4, hold stall 20 cycles → stall_cnt_o=15.
  - cnt_clr_i together with stall → 0 next edge.
- Idle advance: valid_i=0, ctrl_i=8'hFF, ridx_i nonzero → ctrl_o=BUBBLE_CTRL, ridx_o=0, bubble_cnt_o+1.
